riscv_core_div_unit: RTL and testbench
======================================

RISCV_CORE_DIV_UNIT -- requirements
Module: riscv_core_div_unit

Interface
REQ-001 Parameter XLEN, default 64: datapath width; SHALL be even and >= 8.
REQ-002 Parameter EARLY_OUT, default 1: when 1, divide-by-zero and signed-overflow complete without iterating.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_div_valid  input  1  request valid.
REQ-006 o_div_ready  output  1  unit can accept a request.
REQ-007 i_div_srcA  input  XLEN  dividend operand (rs1).
REQ-008 i_div_srcB  input  XLEN  divisor operand (rs2).
REQ-009 i_div_control  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-010 i_div_isword  input  1  1 selects the W variant (low XLEN/2 bits).
REQ-011 i_div_flush  input  1  abort any in-flight operation.
REQ-012 o_div_valid  output  1  result valid.
REQ-013 i_div_out_ready  input  1  consumer accepts the result.
REQ-014 o_div_result  output  XLEN  quotient or remainder.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE; o_div_ready SHALL be 1 only in IDLE with i_div_flush low.
REQ-016 A request SHALL be accepted on a rising edge where i_div_valid and o_div_ready are both 1; operands, control and isword SHALL be registered at that edge.
REQ-017 On acceptance, signed ops (DIV, REM) SHALL convert operands to magnitudes by two's complement.
REQ-018 Operand sign SHALL be taken from bit XLEN-1, or from bit XLEN/2-1 when isword=1, for both DIVW and REMW.
REQ-019 Word ops SHALL use only the low XLEN/2 bits, zero-extended after magnitude conversion.
REQ-020 CALC SHALL run restoring radix-2 division, one quotient bit per cycle, for N = XLEN cycles (N = XLEN/2 when isword=1).
REQ-021 Iterations are counted by a down-counter; CALC SHALL exit to DONE when the counter reaches 0.
REQ-022 Normal latency: accept at edge T, o_div_valid=1 from edge T+N+1.
REQ-023 Sign fixup on entry to DONE: the quotient SHALL be negated when the operand signs differ (signed ops only); the remainder SHALL take the dividend sign.
REQ-024 Divide by zero: quotient SHALL be all ones; remainder SHALL equal the original dividend (word-width for W ops).
REQ-025 Signed overflow (most-negative / -1, at the operating width): quotient SHALL equal the dividend; remainder SHALL be 0.
REQ-026 With EARLY_OUT=1, the cases of REQ-024/025 SHALL go IDLE->DONE, giving o_div_valid at T+1.
REQ-027 With EARLY_OUT=0, the cases of REQ-024/025 SHALL run the full N cycles and still return the values of REQ-024/025.
REQ-028 W-op results SHALL be the XLEN/2-bit result sign-extended to XLEN, for all four W ops.
REQ-029 DONE SHALL hold o_div_valid=1 and o_div_result stable until i_div_out_ready=1, then return to IDLE on that edge.
REQ-030 No new request SHALL be accepted in the cycle DONE is retired (no back-to-back bypass).
REQ-031 i_div_flush=1 SHALL force IDLE on the next edge from any state, with o_div_valid=0 and no result delivered.
REQ-032 Flush SHALL take priority over acceptance and over retirement in the same cycle.
REQ-033 o_div_result SHALL be 0 whenever o_div_valid=0.

Reset
REQ-034 Asserting i_rst SHALL immediately force IDLE, counter 0, and all datapath registers 0.
REQ-035 Under i_rst: o_div_valid=0, o_div_result=0, o_div_ready=0.
REQ-036 o_div_ready SHALL rise only after i_rst deasserts.
REQ-037 An operation interrupted by reset SHALL be discarded.

Structure
REQ-038 Package riscv_core_div_pkg SHALL hold the DIV/DIVU/REM/REMU encodings and the state enum.
REQ-039 Operand sign and magnitude conditioning SHALL live in sub-module riscv_core_div_operand_prep (combinational, parametrised by XLEN); the iterator and fixup stay in the top.

Verification
REQ-040 DIV srcA=-20, srcB=3, XLEN=64 -> result -6 after exactly 65 cycles; REM of the same operands -> -2.
REQ-041 DIVUW srcA=0xFFFFFFFF_80000000, srcB=2 -> 0x00000000_40000000 sign-extended = 0x0000000040000000 at T+33; REMW srcA=0x00000000_FFFFFFF9 (-7), srcB=2 -> 0xFFFFFFFFFFFFFFFF.
REQ-042 DIV by 0 with srcA=5 -> 0xFFFFFFFFFFFFFFFF; REMU by 0 -> 5; with EARLY_OUT=1 both valid at T+1.
REQ-043 DIV 0x8000000000000000 / -1 -> 0x8000000000000000 and REM of the same -> 0; DIVW 0x80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000.
REQ-044 Flush at T+10 of a 64-bit DIV -> IDLE at T+11, o_div_valid never asserted; i_rst pulsed mid-CALC -> outputs 0 immediately.
REQ-045 Hold i_div_out_ready=0 for 5 cycles in DONE -> result stable and o_div_ready=0 throughout; retire -> o_div_ready=1 the next cycle.

Source files
------------

// File: rtl/riscv_core_div_pkg.sv
// Shared encodings, FSM state type and per-operation context for the iterative divider.
package riscv_core_div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Everything the fixup stage needs to know about the accepted request.
    typedef struct packed {
        logic is_rem;
        logic word;
        logic neg_quo;
        logic neg_rem;
        logic by_zero;
        logic ovf;
    } div_ctx_t;

    function automatic logic op_is_signed(input logic [1:0] control);
        return (control == OP_DIV) || (control == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] control);
        return (control == OP_REM) || (control == OP_REMU);
    endfunction

endpackage

// File: rtl/riscv_core_div_operand_prep.sv
// Combinational operand conditioning: width select, sign extraction, magnitudes and
// detection of the divide-by-zero and signed-overflow special cases.
module riscv_core_div_operand_prep
    import riscv_core_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [1:0]      control,
    input  logic            isword,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic [XLEN-1:0] dividend,
    output logic            sign_a,
    output logic            sign_b,
    output logic            div_zero,
    output logic            overflow
);
    localparam int HALF = XLEN / 2;

    logic [XLEN-1:0] a_op;
    logic [XLEN-1:0] b_op;
    logic [XLEN-1:0] most_neg;
    logic [XLEN-1:0] all_ones;
    logic            signed_op;

    // NOTE: every output gets a value on every path before any override, so no latch is inferred.
    always_comb begin
        signed_op = op_is_signed(control);
        a_op      = isword ? {{HALF{1'b0}}, src_a[HALF-1:0]} : src_a;
        b_op      = isword ? {{HALF{1'b0}}, src_b[HALF-1:0]} : src_b;
        most_neg  = isword ? {{HALF{1'b0}}, 1'b1, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        all_ones  = isword ? {{HALF{1'b0}}, {HALF{1'b1}}} : {XLEN{1'b1}};

        sign_a = signed_op & (isword ? src_a[HALF-1] : src_a[XLEN-1]);
        sign_b = signed_op & (isword ? src_b[HALF-1] : src_b[XLEN-1]);

        mag_a = sign_a ? -a_op : a_op;
        mag_b = sign_b ? -b_op : b_op;
        // Negating a zero-extended word spills ones into the upper half; the magnitude is word-wide.
        if (isword) begin
            mag_a[XLEN-1:HALF] = '0;
            mag_b[XLEN-1:HALF] = '0;
        end

        dividend = a_op;
        div_zero = (b_op == '0);
        overflow = signed_op && (a_op == most_neg) && (b_op == all_ones);
    end

endmodule

// File: rtl/riscv_core_div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU and their W variants,
// one quotient bit per cycle, with valid/ready handshakes and flush.
module riscv_core_div_unit
    import riscv_core_div_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_div_valid,
    output logic            o_div_ready,
    input  logic [XLEN-1:0] i_div_srcA,
    input  logic [XLEN-1:0] i_div_srcB,
    input  logic [1:0]      i_div_control,
    input  logic            i_div_isword,
    input  logic            i_div_flush,
    output logic            o_div_valid,
    input  logic            i_div_out_ready,
    output logic [XLEN-1:0] o_div_result
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 1);

    div_state_e      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] dividend;
    div_ctx_t        ctx;
    logic            valid_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] prep_mag_a;
    logic [XLEN-1:0] prep_mag_b;
    logic [XLEN-1:0] prep_dividend;
    logic            prep_sign_a;
    logic            prep_sign_b;
    logic            prep_zero;
    logic            prep_ovf;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] sel;
    logic [XLEN-1:0] fixed;
    logic            accept;

    riscv_core_div_operand_prep #(.XLEN(XLEN)) u_prep (
        .src_a    (i_div_srcA),
        .src_b    (i_div_srcB),
        .control  (i_div_control),
        .isword   (i_div_isword),
        .mag_a    (prep_mag_a),
        .mag_b    (prep_mag_b),
        .dividend (prep_dividend),
        .sign_a   (prep_sign_a),
        .sign_b   (prep_sign_b),
        .div_zero (prep_zero),
        .overflow (prep_ovf)
    );

    assign o_div_ready  = (state == S_IDLE) && !i_div_flush && !i_rst;
    assign accept       = i_div_valid && o_div_ready;
    assign o_div_valid  = valid_q;
    assign o_div_result = result_q;

    // Partial remainder is kept below the divisor, so one extra bit covers the shifted value.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {1'b0, divisor};
    end

    always_comb begin
        quo_fix = ctx.neg_quo ? -quo : quo;
        rem_fix = ctx.neg_rem ? -rem : rem;
        if (ctx.by_zero) begin
            quo_fix = '1;
            rem_fix = dividend;
        end else if (ctx.ovf) begin
            quo_fix = dividend;
            rem_fix = '0;
        end
        sel   = ctx.is_rem ? rem_fix : quo_fix;
        fixed = ctx.word ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
    end

    // NOTE: all state lives in this block and uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            dividend <= '0;
            ctx      <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (i_div_flush) begin
            state    <= S_IDLE;
            count    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        // W dividends sit in the upper half so their MSB is shifted out first.
                        quo          <= i_div_isword ? {prep_mag_a[HALF-1:0], {HALF{1'b0}}} : prep_mag_a;
                        rem          <= '0;
                        divisor      <= prep_mag_b;
                        dividend     <= prep_dividend;
                        ctx.is_rem   <= op_is_rem(i_div_control);
                        ctx.word     <= i_div_isword;
                        ctx.neg_quo  <= prep_sign_a ^ prep_sign_b;
                        ctx.neg_rem  <= prep_sign_a;
                        ctx.by_zero  <= prep_zero;
                        ctx.ovf      <= prep_ovf;
                        if (EARLY_OUT && (prep_zero || prep_ovf)) begin
                            state <= S_DONE;
                            count <= '0;
                        end else begin
                            state <= S_CALC;
                            count <= i_div_isword ? CW'(HALF) : CW'(XLEN);
                        end
                    end
                end
                S_CALC: begin
                    if (!trial[XLEN]) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle registers the fixed-up result; later cycles wait for the consumer.
                    if (!valid_q) begin
                        valid_q  <= 1'b1;
                        result_q <= fixed;
                    end else if (i_div_out_ready) begin
                        valid_q  <= 1'b0;
                        result_q <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_div_unit.sv
// Self-checking bench: directed corner cases plus random operations against an arithmetic model.
module tb_riscv_core_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        dvalid;
    logic        dready;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic [1:0]  ctl;
    logic        isword;
    logic        flush;
    logic        ovalid;
    logic        out_ready;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_core_div_unit #(.XLEN(64), .EARLY_OUT(1'b1)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_div_valid     (dvalid),
        .o_div_ready     (dready),
        .i_div_srcA      (src_a),
        .i_div_srcB      (src_b),
        .i_div_control   (ctl),
        .i_div_isword    (isword),
        .i_div_flush     (flush),
        .o_div_valid     (ovalid),
        .i_div_out_ready (out_ready),
        .o_div_result    (result)
    );

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                               input logic [1:0] c, input logic w);
        longint      sa;
        longint      sb;
        int          wa;
        int          wb;
        logic [31:0] r32;
        logic [63:0] r;
        logic        ovf;
        sa  = a;
        sb  = b;
        wa  = a[31:0];
        wb  = b[31:0];
        r   = '0;
        r32 = '0;
        if (!w) begin
            ovf = (a == 64'h8000_0000_0000_0000) && (sb == -1);
            case (c)
                2'b00: if (b == 0) r = '1; else if (ovf) r = a; else r = sa / sb;
                2'b01: if (b == 0) r = '1; else r = a / b;
                2'b10: if (b == 0) r = a; else if (ovf) r = 64'd0; else r = sa % sb;
                default: if (b == 0) r = a; else r = a % b;
            endcase
        end else begin
            ovf = (a[31:0] == 32'h8000_0000) && (wb == -1);
            case (c)
                2'b00: if (wb == 0) r32 = '1; else if (ovf) r32 = a[31:0]; else r32 = wa / wb;
                2'b01: if (wb == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
                2'b10: if (wb == 0) r32 = a[31:0]; else if (ovf) r32 = 32'd0; else r32 = wa % wb;
                default: if (wb == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [63:0] a, input logic [63:0] b,
                                       input logic [1:0] c, input logic w);
        logic zero;
        logic ovf;
        logic sgn;
        sgn  = (c == 2'b00) || (c == 2'b10);
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        if (zero || ovf) return 1;
        return w ? 33 : 65;
    endfunction

    // Called at a falling edge; returns at the falling edge just after the acceptance edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c, input logic w);
        int n;
        n = 0;
        while (!dready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", 64'(dready), 64'd1);
        src_a  = a;
        src_b  = b;
        ctl    = c;
        isword = w;
        dvalid = 1'b1;
        @(negedge clk);
        dvalid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!ovalid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] c, input logic w,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        issue(a, b, c, w);
        wait_valid(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " retired valid/ready"}, {62'd0, ovalid, dready}, 64'b01);
        check({tag, " result cleared"}, result, 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  c;
        logic        w;
        logic        seen;
        int          lat;

        rst       = 1'b1;
        dvalid    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        src_a     = '0;
        src_b     = '0;
        ctl       = 2'b00;
        isword    = 1'b0;

        repeat (3) @(negedge clk);
        check("reset valid", 64'(ovalid), 64'd0);
        check("reset result", result, 64'd0);
        check("reset ready", 64'(dready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready after reset", 64'(dready), 64'd1);

        run_op("DIV -20/3", 64'(-20), 64'd3, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        run_op("REM -20/3", 64'(-20), 64'd3, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("DIVUW", 64'hFFFF_FFFF_8000_0000, 64'd2, 2'b01, 1'b1, 64'h0000_0000_4000_0000, 33);
        run_op("REMW -7/2", 64'h0000_0000_FFFF_FFF9, 64'd2, 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("DIV by zero", 64'd5, 64'd0, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("REMU by zero", 64'd5, 64'd0, 2'b11, 1'b0, 64'd5, 1);
        run_op("DIV overflow", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0,
               64'h8000_0000_0000_0000, 1);
        run_op("REM overflow", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'd0, 1);
        run_op("DIVW overflow", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1,
               64'hFFFF_FFFF_8000_0000, 1);

        // Consumer back-pressure: result held, unit busy.
        issue(64'd1000, 64'd7, 2'b01, 1'b0);
        wait_valid(lat);
        check("hold latency", 64'(lat), 64'd65);
        for (int k = 0; k < 5; k++) begin
            check("hold result", result, 64'd142);
            check("hold valid", 64'(ovalid), 64'd1);
            check("hold ready", 64'(dready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ready after retire", 64'(dready), 64'd1);

        // Flush during a 64-bit DIV.
        issue(64'd123456789, 64'd97, 2'b00, 1'b0);
        repeat (5) @(negedge clk);
        check("mid calc result zero", result, 64'd0);
        check("mid calc ready", 64'(dready), 64'd0);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        #1;
        check("ready low under flush", 64'(dready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("idle after flush", 64'(dready), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            seen = seen | ovalid;
        end
        check("no valid after flush", 64'(seen), 64'd0);

        // Flush beats a request presented in the same cycle.
        src_a  = 64'd50;
        src_b  = 64'd5;
        ctl    = 2'b01;
        isword = 1'b0;
        dvalid = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        dvalid = 1'b0;
        flush  = 1'b0;
        #1;
        check("flush blocks accept", 64'(dready), 64'd1);
        @(negedge clk);

        // Reset pulsed mid-CALC and while a result is waiting.
        issue(64'd999, 64'd3, 2'b00, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst mid calc outputs", {62'd0, ovalid, dready}, 64'd0);
        check("rst mid calc result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready after mid calc rst", 64'(dready), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            seen = seen | ovalid;
        end
        check("no valid after rst", 64'(seen), 64'd0);

        issue(64'd9, 64'd0, 2'b01, 1'b0);
        wait_valid(lat);
        check("pre-rst done result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        rst = 1'b1;
        #1;
        check("rst in done valid", 64'(ovalid), 64'd0);
        check("rst in done result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = w ? {$urandom, 32'd0} : 64'd0;
                1: b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                2: begin
                    a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                3: b = 64'($urandom_range(1, 20));
                4: b = b >> $urandom_range(0, 60);
                default: ;
            endcase
            run_op("random", a, b, c, w, ref_result(a, b, c, w), ref_latency(a, b, c, w));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
